dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning number of 64-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, meaning wait cycles between acceptance and response (legal 0..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port acs_en  input  1  request valid; the initiator holds it until acs_ready.
REQ-007 SHALL have port acs_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port acs_bytes  input  8  byte-lane strobe; bit i enables byte lane i.
REQ-009 SHALL have port acs_addr  input  64  byte address; bits [2:0] are ignored for word indexing.
REQ-010 SHALL have port acs_wdata  input  64  write data, lane-aligned.
REQ-011 SHALL have port acs_rdata  output  64  read data, full 64-bit word.
REQ-012 SHALL have port acs_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port acs_err  output  1  access fault; meaningful only while acs_ready=1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 IDLE with acs_en=1 SHALL capture acs_wr/acs_bytes/acs_addr/acs_wdata into internal registers (the acceptance edge) and transition to WAIT, loading the counter with LATENCY-1; when LATENCY=0 it SHALL go directly to RESP.
REQ-017 WAIT SHALL decrement the counter each cycle and transition to RESP on the cycle the counter equals 0.
REQ-018 RESP SHALL drive acs_ready=1 for exactly one cycle, then return to IDLE.
REQ-019 acs_ready SHALL rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 Requests SHALL be accepted only in IDLE; acs_en in WAIT/RESP is ignored, so the earliest next acceptance is the edge ending the RESP cycle+1, giving a throughput of one request per LATENCY+2 cycles.
REQ-021 Input changes after acceptance SHALL have no effect on the pending access.
REQ-022 Word index SHALL be (captured_addr - ADDR_BASE) >> 3; the access is in range iff captured_addr >= ADDR_BASE and index < DEPTH_WORDS, with the subtraction evaluated unsigned at 64 bits.
REQ-023 An in-range write SHALL update only the byte lanes with strobe=1, at the clock edge ending the RESP cycle.
REQ-024 An in-range read SHALL present the full stored word on acs_rdata during RESP, ignoring strobes.
REQ-025 acs_rdata SHALL hold its last value until the next read response; writes and errored accesses leave it unchanged.
REQ-026 acs_err SHALL be 1 in RESP for an out-of-range access, or for a write with acs_bytes=8'h00; errored accesses SHALL modify no storage.
REQ-027 LATENCY values outside 0..15 SHALL be rejected at elaboration.

Reset
REQ-028 While rstn=0 the block SHALL hold state=IDLE, acs_ready=0, acs_err=0, acs_rdata=64'h0, busy=0, counter=0.
REQ-029 Storage contents SHALL NOT be reset; reset asserted in WAIT or RESP SHALL abort the pending access with no storage write and no acs_ready pulse.
REQ-030 The first acceptance after reset SHALL occur no earlier than the first rising edge with rstn=1.

Verification
REQ-031 LATENCY=2: write 0x8000_0008, wdata 64'h1122334455667788, bytes 8'hFF -> acs_ready at acceptance+3, err=0; then read 0x8000_0008 -> rdata 64'h1122334455667788.
REQ-032 Partial write to 0x8000_0008 with wdata 64'hAAAAAAAAAAAAAAAA, bytes 8'h0F -> subsequent read returns 64'h11223344AAAAAAAA.
REQ-033 Write to 0x7FFF_FFF8 and read of ADDR_BASE+DEPTH_WORDS*8 -> both respond with err=1; a read of 0x8000_0008 is unchanged and rdata keeps its prior value.
REQ-034 rstn pulsed low during WAIT of a write to 0x8000_0010 -> no acs_ready pulse, busy=0 immediately; a later read returns the pre-write contents.
REQ-035 LATENCY=0 with acs_en held high continuously -> acs_ready pulses every 2 cycles; busy toggles accordingly.
REQ-036 acs_addr/acs_wdata changed every cycle during WAIT -> the response and storage reflect only the values captured at acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port 64-bit data memory behind a one-outstanding-request
// handshake. A request is captured in IDLE, waits LATENCY cycles, then RESP
// returns a one-cycle acs_ready pulse with read data or an access fault.
module dmem_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        acs_en,
    input  logic        acs_wr,
    input  logic [7:0]  acs_bytes,
    input  logic [63:0] acs_addr,
    input  logic [63:0] acs_wdata,
    output logic [63:0] acs_rdata,
    output logic        acs_ready,
    output logic        acs_err,
    output logic        busy
);

    // Handshake: the initiator raises acs_en with a stable request and holds it
    // until acs_ready; the request is taken on the first rising edge seen in
    // IDLE, and acs_ready is high for exactly the single RESP cycle.

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] DEPTH64  = 64'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 0..15");
        end
        if (DEPTH_WORDS < 1 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        cap_wr;
    logic [7:0]  cap_bytes;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [63:0] rdata_q;

    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0]      off;
    logic             in_range;
    logic             fault;
    logic [IDX_W-1:0] idx;
    logic [63:0]      rd_word;
    logic             rd_hit;

    // Address decode on the captured request only, so late input changes cannot leak in.
    always_comb begin
        off      = cap_addr - ADDR_BASE;
        in_range = (cap_addr >= ADDR_BASE) && ((off >> 3) < DEPTH64);
        fault    = !in_range || (cap_wr && (cap_bytes == 8'h00));
        idx      = off[IDX_W+2:3];
        rd_word  = mem[idx];
        rd_hit   = (state == S_RESP) && !cap_wr && !fault;
    end

    // Request FSM: capture in IDLE, count down in WAIT, one-cycle RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_wr    <= 1'b0;
            cap_bytes <= 8'h00;
            cap_addr  <= 64'h0;
            cap_wdata <= 64'h0;
            rdata_q   <= 64'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acs_en) begin
                        cap_wr    <= acs_wr;
                        cap_bytes <= acs_bytes;
                        cap_addr  <= acs_addr;
                        cap_wdata <= acs_wdata;
                        cnt       <= CNT_LOAD;
                        state     <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (rd_hit) begin
                        rdata_q <= rd_word;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage write on the edge ending RESP; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rstn && (state == S_RESP) && cap_wr && !fault) begin
            for (int i = 0; i < 8; i++) begin
                if (cap_bytes[i]) begin
                    mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    assign acs_ready = (state == S_RESP);
    assign acs_err   = acs_ready && fault;
    assign busy      = (state != S_IDLE);
    // During a good read RESP the word is shown directly; otherwise the last read value holds.
    assign acs_rdata = rd_hit ? rd_word : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of directed accesses on a LATENCY=2 instance,
// plus hand sequences for reset abort and back-to-back LATENCY=0 traffic.
module tb_dmem_responder;

    logic        clk;
    logic        rstn;

    logic        en,  wr;
    logic [7:0]  bytes;
    logic [63:0] addr, wdata, rdata;
    logic        ready, err, busy;

    logic        en0, wr0;
    logic [7:0]  bytes0;
    logic [63:0] addr0, wdata0, rdata0;
    logic        ready0, err0, busy0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  bytes;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        scramble;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[17];

    dmem_responder #(.LATENCY(2)) u_dut (
        .clk(clk), .rstn(rstn), .acs_en(en), .acs_wr(wr), .acs_bytes(bytes),
        .acs_addr(addr), .acs_wdata(wdata), .acs_rdata(rdata),
        .acs_ready(ready), .acs_err(err), .busy(busy)
    );

    dmem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .acs_en(en0), .acs_wr(wr0), .acs_bytes(bytes0),
        .acs_addr(addr0), .acs_wdata(wdata0), .acs_rdata(rdata0),
        .acs_ready(ready0), .acs_err(err0), .busy(busy0)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; response expected 3 samples after acceptance.
    task automatic do_access(input vec_t v, input int n);
        int  k;
        bit  seen;
        @(negedge clk);
        en = 1'b1; wr = v.wr; bytes = v.bytes; addr = v.addr; wdata = v.wdata;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (ready) begin
                seen = 1'b1;
            end else if (v.scramble) begin
                addr  = {$urandom, $urandom};
                wdata = {$urandom, $urandom};
                bytes = 8'($urandom_range(0, 255));
                wr    = 1'($urandom_range(0, 1));
            end
        end
        check($sformatf("latency[%0d]", n), 64'(k), 64'd3);
        if (seen) begin
            check($sformatf("err[%0d]", n), 64'(err), 64'(v.exp_err));
            check($sformatf("rdata[%0d]", n), rdata, v.exp_rdata);
        end
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ready;
        vec_t v;

        //            wr    bytes  addr                    wdata                   scr   err   rdata
        vecs[0]  = '{1'b1, 8'hFF, 64'h0000_0000_8000_0008, 64'h1122334455667788, 1'b0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 8'h00, 64'h0000_0000_8000_0008, 64'h0,                1'b0, 1'b0, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 8'h0F, 64'h0000_0000_8000_0008, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0, 64'h1122334455667788};
        vecs[3]  = '{1'b0, 8'h00, 64'h0000_0000_8000_000D, 64'h0,                1'b0, 1'b0, 64'h11223344AAAAAAAA};
        vecs[4]  = '{1'b1, 8'hFF, 64'h0000_0000_7FFF_FFF8, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b1, 64'h11223344AAAAAAAA};
        vecs[5]  = '{1'b0, 8'hFF, 64'h0000_0000_8000_8000, 64'h0,                1'b0, 1'b1, 64'h11223344AAAAAAAA};
        vecs[6]  = '{1'b0, 8'h00, 64'h0000_0000_8000_0008, 64'h0,                1'b0, 1'b0, 64'h11223344AAAAAAAA};
        vecs[7]  = '{1'b1, 8'hFF, 64'h0000_0000_8000_0010, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h11223344AAAAAAAA};
        vecs[8]  = '{1'b1, 8'h00, 64'h0000_0000_8000_0010, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 64'h11223344AAAAAAAA};
        vecs[9]  = '{1'b0, 8'h00, 64'h0000_0000_8000_0010, 64'h0,                1'b0, 1'b0, 64'h0123456789ABCDEF};
        vecs[10] = '{1'b1, 8'hFF, 64'h0000_0000_8000_7FF8, 64'hCAFEF00DBEEF1234, 1'b0, 1'b0, 64'h0123456789ABCDEF};
        vecs[11] = '{1'b1, 8'h81, 64'h0000_0000_8000_7FF8, 64'h9999999999999999, 1'b0, 1'b0, 64'h0123456789ABCDEF};
        vecs[12] = '{1'b0, 8'h00, 64'h0000_0000_8000_7FF8, 64'h0,                1'b0, 1'b0, 64'h99FEF00DBEEF1299};
        vecs[13] = '{1'b1, 8'hFF, 64'h0000_0000_8000_0018, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0, 64'h99FEF00DBEEF1299};
        vecs[14] = '{1'b0, 8'h00, 64'h0000_0000_8000_0018, 64'h0,                1'b1, 1'b0, 64'h0F0E0D0C0B0A0908};
        vecs[15] = '{1'b0, 8'h00, 64'h0000_0000_0000_0000, 64'h0,                1'b0, 1'b1, 64'h0F0E0D0C0B0A0908};
        vecs[16] = '{1'b0, 8'h00, 64'hFFFF_FFFF_8000_0008, 64'h0,                1'b0, 1'b1, 64'h0F0E0D0C0B0A0908};

        // reset
        rstn = 1'b0;
        en = 1'b0; wr = 1'b0; bytes = 8'h00; addr = 64'h0; wdata = 64'h0;
        en0 = 1'b0; wr0 = 1'b0; bytes0 = 8'h00; addr0 = 64'h0; wdata0 = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_err",   64'(err),   64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_rdata", rdata,      64'h0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_rdata0", rdata0,    64'h0);
        rstn = 1'b1;

        // directed table on LATENCY=2
        for (int i = 0; i < 17; i++) begin
            do_access(vecs[i], i);
        end

        // reset asserted during WAIT of a write aborts it
        @(negedge clk);
        en = 1'b1; wr = 1'b1; bytes = 8'hFF; addr = 64'h8000_0010; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("abort_busy_wait", 64'(busy), 64'd1);
        en = 1'b0;
        rstn = 1'b0;
        #1;
        check("abort_busy_rst",  64'(busy),  64'd0);
        check("abort_ready_rst", 64'(ready), 64'd0);
        saw_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        check("abort_no_ready", 64'(saw_ready), 64'd0);
        v = '{1'b0, 8'h00, 64'h8000_0010, 64'h0, 1'b0, 1'b0, 64'h0123456789ABCDEF};
        do_access(v, 100);

        // LATENCY=0 with acs_en held high: ready and busy every other cycle
        @(negedge clk);
        en0 = 1'b1; wr0 = 1'b1; bytes0 = 8'hFF; addr0 = 64'h8000_0000; wdata0 = 64'h0123_4567_0000_FFFF;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("l0_ready[%0d]", i), 64'(ready0), 64'(i % 2));
            check($sformatf("l0_busy[%0d]", i),  64'(busy0),  64'(i % 2));
            if (ready0) check($sformatf("l0_err[%0d]", i), 64'(err0), 64'd0);
        end
        en0 = 1'b0;
        @(negedge clk);
        en0 = 1'b1; wr0 = 1'b0;
        @(negedge clk);
        check("l0_rd_ready", 64'(ready0), 64'd1);
        check("l0_rd_err",   64'(err0),   64'd0);
        check("l0_rd_rdata", rdata0,      64'h0123_4567_0000_FFFF);
        en0 = 1'b0;
        @(negedge clk);
        check("l0_idle_ready", 64'(ready0), 64'd0);
        check("l0_hold_rdata", rdata0,      64'h0123_4567_0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
